host_cmd_queue: RTL and testbench

HOST_CMD_QUEUE -- requirements
Module: host_cmd_queue

---
 rtl/host_cmd_queue.sv | 222 ++++++++++++++++++++++
 tb/tb_host_cmd_queue.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/host_cmd_queue.sv
// host_cmd_queue
//   Parses a byte stream of host command frames into {r_w, target, length,
//   address} entries and queues them in a small circular FIFO for a consumer.
//   Frames aimed at target 2'b11 are swallowed and counted as errors.
//   A separate pending-ack counter turns txn_done pulses into ack-bus
//   requests that are retired one per granted cycle.
//
//   Frame layout: opcode, LEN_BYTES length bytes, ADDR_BYTES address bytes,
//   multi-byte fields MSB first. Opcode bit7 = r_w, bits6:5 = target.
//
// Ports
//   clk, rst_n          clock, synchronous active-low reset
//   in_valid/in_data    host byte stream, in_ready back-pressure
//   cmd_*               head of the command queue (valid/ready handshake)
//   ena_fsm/qspi/status one-hot target decode of a valid head
//   txn_done            transaction-complete pulse (raises a pending ack)
//   ack_req/ack_id      ack-bus request and fixed id, ack_grant retires one
//   fifo_count          queued entries
//   err_count           saturating count of dropped (target 11) frames
module host_cmd_queue #(
  parameter int          LEN_W      = 9,
  parameter int          ADDR_BYTES = 3,
  parameter int          DEPTH      = 4,
  parameter logic [1:0]  ACK_ID     = 2'b01,
  localparam int         ADDR_W     = 8 * ADDR_BYTES,
  localparam int         CNT_W      = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              cmd_valid,
  input  logic              cmd_ready,
  output logic              cmd_r_w,
  output logic [1:0]        cmd_target,
  output logic [LEN_W-1:0]  cmd_length,
  output logic [ADDR_W-1:0] cmd_address,
  output logic              ena_fsm,
  output logic              ena_qspi,
  output logic              ena_status,
  input  logic              txn_done,
  output logic              ack_req,
  output logic [1:0]        ack_id,
  input  logic              ack_grant,
  output logic [CNT_W-1:0]  fifo_count,
  output logic [7:0]        err_count
);

  localparam int LEN_BYTES = (LEN_W + 7) / 8;
  localparam int MAX_BYTES = (LEN_BYTES > ADDR_BYTES) ? LEN_BYTES : ADDR_BYTES;
  localparam int BCNT_W    = (MAX_BYTES > 1) ? $clog2(MAX_BYTES) : 1;
  localparam int PTR_W     = $clog2(DEPTH);
  localparam int ENTRY_W   = 3 + LEN_W + ADDR_W;

  localparam logic [1:0] S_OP     = 2'd0;
  localparam logic [1:0] S_LEN    = 2'd1;
  localparam logic [1:0] S_ADDR   = 2'd2;
  localparam logic [1:0] TGT_DROP = 2'b11;

  // Parser state
  logic [1:0]        state_reg, state_next;
  logic [BCNT_W-1:0] byte_cnt_reg, byte_cnt_next;
  logic              r_w_reg;
  logic [1:0]        target_reg;
  logic [LEN_W-1:0]  len_acc_reg;
  logic [ADDR_W-1:0] addr_acc_reg;

  // Queue state
  logic [ENTRY_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_reg, rd_ptr_reg;
  logic [CNT_W-1:0]   count_reg;
  logic [7:0]         err_count_reg;
  logic [CNT_W-1:0]   ack_pend_reg;

  logic               last_len_byte, last_addr_byte, queue_full, frame_drop;
  logic               byte_acc, frame_end, push, drop, pop, ack_dec;
  logic [LEN_W-1:0]   len_shift;
  logic [ADDR_W-1:0]  addr_shift;
  logic [ENTRY_W-1:0] entry_in, head_entry;

  assign last_len_byte  = (byte_cnt_reg == BCNT_W'(LEN_BYTES - 1));
  assign last_addr_byte = (state_reg == S_ADDR) &&
                          (byte_cnt_reg == BCNT_W'(ADDR_BYTES - 1));
  assign queue_full     = (count_reg == CNT_W'(DEPTH));
  assign frame_drop     = (target_reg == TGT_DROP);

  // Only the byte that would push into a full queue is held off; dropped
  // frames never push, so they always flow through. Using the registered
  // count means a same-cycle pop cannot open the door.
  assign in_ready  = !(last_addr_byte && queue_full && !frame_drop);
  assign byte_acc  = in_valid && in_ready;
  assign frame_end = byte_acc && last_addr_byte;
  assign push      = frame_end && !frame_drop;
  assign drop      = frame_end && frame_drop;
  assign cmd_valid = (count_reg != '0);
  assign pop       = cmd_valid && cmd_ready;

  // Shift-in accumulators; the cast keeps the low bits, which also truncates
  // an over-wide length to LEN_W.
  assign len_shift  = LEN_W'({len_acc_reg, in_data});
  assign addr_shift = ADDR_W'({addr_acc_reg, in_data});
  assign entry_in   = {r_w_reg, target_reg, len_acc_reg, addr_shift};

  always_comb begin
    state_next    = state_reg;
    byte_cnt_next = byte_cnt_reg;
    if (byte_acc) begin
      case (state_reg)
        S_OP: begin
          state_next    = S_LEN;
          byte_cnt_next = '0;
        end
        S_LEN: begin
          if (last_len_byte) begin
            state_next    = S_ADDR;
            byte_cnt_next = '0;
          end else begin
            byte_cnt_next = byte_cnt_reg + 1'b1;
          end
        end
        S_ADDR: begin
          if (last_addr_byte) begin
            state_next    = S_OP;
            byte_cnt_next = '0;
          end else begin
            byte_cnt_next = byte_cnt_reg + 1'b1;
          end
        end
        default: begin
          state_next    = S_OP;
          byte_cnt_next = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg     <= S_OP;
      byte_cnt_reg  <= '0;
      r_w_reg       <= 1'b0;
      target_reg    <= 2'b00;
      len_acc_reg   <= '0;
      addr_acc_reg  <= '0;
      wr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
      count_reg     <= '0;
      err_count_reg <= '0;
    end else begin
      state_reg    <= state_next;
      byte_cnt_reg <= byte_cnt_next;
      if (byte_acc && state_reg == S_OP) begin
        r_w_reg    <= in_data[7];
        target_reg <= in_data[6:5];
      end
      if (byte_acc && state_reg == S_LEN) begin
        len_acc_reg <= len_shift;
      end
      if (byte_acc && state_reg == S_ADDR) begin
        addr_acc_reg <= addr_shift;
      end
      // DEPTH is a power of two, so pointers wrap by overflow.
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
      case ({push, pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
      if (drop && err_count_reg != 8'hFF) begin
        err_count_reg <= err_count_reg + 1'b1;
      end
    end
  end

  // Storage is not reset so it maps onto distributed RAM; the head is
  // masked while the queue is empty, which keeps cmd_* at zero after reset.
  always_ff @(posedge clk) begin
    if (rst_n && push) begin
      mem[wr_ptr_reg] <= entry_in;
    end
  end

  assign head_entry = cmd_valid ? mem[rd_ptr_reg] : '0;
  assign {cmd_r_w, cmd_target, cmd_length, cmd_address} = head_entry;

  logic [2:0] ena_vec;
  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_ena
      assign ena_vec[gi] = cmd_valid && (cmd_target == 2'(gi));
    end
  endgenerate
  assign ena_fsm    = ena_vec[0];
  assign ena_qspi   = ena_vec[1];
  assign ena_status = ena_vec[2];

  // Pending acks: a raise and a retire in the same cycle cancel out.
  assign ack_req = (ack_pend_reg != '0);
  assign ack_dec = ack_req && ack_grant;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ack_pend_reg <= '0;
    end else if (txn_done && !ack_dec) begin
      if (ack_pend_reg != CNT_W'(DEPTH)) begin
        ack_pend_reg <= ack_pend_reg + 1'b1;
      end
    end else if (ack_dec && !txn_done) begin
      ack_pend_reg <= ack_pend_reg - 1'b1;
    end
  end

  assign ack_id     = ACK_ID;
  assign fifo_count = count_reg;
  assign err_count  = err_count_reg;

endmodule

// File: tb/tb_host_cmd_queue.sv
module tb_host_cmd_queue;

  localparam int LEN_W      = 9;
  localparam int ADDR_BYTES = 3;
  localparam int DEPTH      = 4;
  localparam int ADDR_W     = 8 * ADDR_BYTES;
  localparam int LEN_BYTES  = (LEN_W + 7) / 8;
  localparam int FRAME      = 1 + LEN_BYTES + ADDR_BYTES;
  localparam int CNT_W      = $clog2(DEPTH + 1);

  logic              clk;
  logic              rst_n;
  logic              in_valid;
  logic [7:0]        in_data;
  logic              in_ready;
  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_r_w;
  logic [1:0]        cmd_target;
  logic [LEN_W-1:0]  cmd_length;
  logic [ADDR_W-1:0] cmd_address;
  logic              ena_fsm, ena_qspi, ena_status;
  logic              txn_done;
  logic              ack_req;
  logic [1:0]        ack_id;
  logic              ack_grant;
  logic [CNT_W-1:0]  fifo_count;
  logic [7:0]        err_count;

  host_cmd_queue #(
    .LEN_W(LEN_W), .ADDR_BYTES(ADDR_BYTES), .DEPTH(DEPTH), .ACK_ID(2'b01)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_r_w(cmd_r_w),
    .cmd_target(cmd_target), .cmd_length(cmd_length), .cmd_address(cmd_address),
    .ena_fsm(ena_fsm), .ena_qspi(ena_qspi), .ena_status(ena_status),
    .txn_done(txn_done), .ack_req(ack_req), .ack_id(ack_id), .ack_grant(ack_grant),
    .fifo_count(fifo_count), .err_count(err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: a frame is a list of bytes, the queue is a list of
  // decoded commands, acks are a plain integer count.
  typedef struct packed {
    logic              r_w;
    logic [1:0]        tgt;
    logic [LEN_W-1:0]  len;
    logic [ADDR_W-1:0] addr;
  } entry_t;

  entry_t     mq[$];
  logic [7:0] fb[$];
  int         m_err;
  int         m_pend;
  int         vectors;
  int         miscompares;
  bit         acc_o;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic bit m_in_ready();
    return !(fb.size() == FRAME - 1 && mq.size() == DEPTH && fb[0][6:5] != 2'b11);
  endfunction

  task automatic model_clear();
    mq.delete();
    fb.delete();
    m_err  = 0;
    m_pend = 0;
  endtask

  task automatic model_frame_done();
    entry_t e;
    longint full;
    e.r_w = fb[0][7];
    e.tgt = fb[0][6:5];
    full = 0;
    for (int i = 1; i <= LEN_BYTES; i++) full = (full << 8) | longint'(fb[i]);
    e.len = full[LEN_W-1:0];
    full = 0;
    for (int i = 1 + LEN_BYTES; i < FRAME; i++) full = (full << 8) | longint'(fb[i]);
    e.addr = full[ADDR_W-1:0];
    if (e.tgt == 2'b11) begin
      if (m_err < 255) m_err++;
    end else begin
      mq.push_back(e);
    end
    fb.delete();
  endtask

  task automatic check_outputs();
    entry_t h;
    bit     hv;
    hv = (mq.size() != 0);
    h  = hv ? mq[0] : '0;
    chk("in_ready",   in_ready,   m_in_ready());
    chk("cmd_valid",  cmd_valid,  hv);
    chk("fifo_count", fifo_count, mq.size());
    chk("cmd_r_w",    cmd_r_w,    h.r_w);
    chk("cmd_target", cmd_target, h.tgt);
    chk("cmd_length", cmd_length, h.len);
    chk("cmd_addr",   cmd_address, h.addr);
    chk("ena_fsm",    ena_fsm,    hv && h.tgt == 2'd0);
    chk("ena_qspi",   ena_qspi,   hv && h.tgt == 2'd1);
    chk("ena_status", ena_status, hv && h.tgt == 2'd2);
    chk("err_count",  err_count,  m_err);
    chk("ack_req",    ack_req,    m_pend != 0);
    chk("ack_id",     ack_id,     2'b01);
  endtask

  // One clock: drive, check the pre-edge outputs, advance the model.
  task automatic cycle(input logic v, input logic [7:0] d, input logic rdy,
                       input logic td, input logic gr, output bit acc);
    bit pop, dec;
    in_valid  = v;
    in_data   = d;
    cmd_ready = rdy;
    txn_done  = td;
    ack_grant = gr;
    @(negedge clk);
    check_outputs();
    acc = v && m_in_ready() && rst_n;
    pop = rdy && mq.size() != 0;
    dec = gr && m_pend != 0;
    @(posedge clk);
    if (!rst_n) begin
      model_clear();
    end else begin
      if (pop) void'(mq.pop_front());
      if (acc) begin
        fb.push_back(d);
        if (fb.size() == FRAME) model_frame_done();
      end
      if (td && !dec) begin
        if (m_pend < DEPTH) m_pend++;
      end else if (dec && !td) begin
        m_pend--;
      end
    end
    #1;
  endtask

  task automatic send_byte(input logic [7:0] d, input logic rdy);
    bit acc;
    int tries;
    acc = 0;
    tries = 0;
    while (!acc && tries < 16) begin
      cycle(1'b1, d, rdy, 1'b0, 1'b0, acc);
      tries++;
    end
    if (!acc) begin
      vectors++;
      miscompares++;
      $error("FAIL send_byte_timeout observed=stalled expected=accepted byte=0x%0h", d);
    end
  endtask

  task automatic send_frame(input logic [7:0] op, input logic [15:0] len,
                            input logic [23:0] addr, input logic rdy);
    send_byte(op, rdy);
    send_byte(len[15:8], rdy);
    send_byte(len[7:0], rdy);
    send_byte(addr[23:16], rdy);
    send_byte(addr[15:8], rdy);
    send_byte(addr[7:0], rdy);
  endtask

  task automatic idle(input int n, input logic rdy);
    for (int i = 0; i < n; i++) cycle(1'b0, 8'h00, rdy, 1'b0, 1'b0, acc_o);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    idle(2, 1'b0);
    rst_n = 1'b1;
  endtask

  initial begin
    int g;
    vectors     = 0;
    miscompares = 0;
    rst_n       = 1'b0;
    in_valid    = 1'b0;
    in_data     = 8'h00;
    cmd_ready   = 1'b0;
    txn_done    = 1'b0;
    ack_grant   = 1'b0;
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Reset state
    chk("rst_in_ready",  in_ready,    1'b1);
    chk("rst_cmd_valid", cmd_valid,   1'b0);
    chk("rst_count",     fifo_count,  0);
    chk("rst_ack_req",   ack_req,     1'b0);
    chk("rst_err",       err_count,   0);
    chk("rst_addr",      cmd_address, 0);

    // Basic frame, latency one cycle after the last byte
    send_frame(8'h20, 16'h0010, 24'h123456, 1'b0);
    chk("f1_valid",  cmd_valid,   1'b1);
    chk("f1_rw",     cmd_r_w,     1'b0);
    chk("f1_tgt",    cmd_target,  2'b01);
    chk("f1_len",    cmd_length,  9'h010);
    chk("f1_addr",   cmd_address, 24'h123456);
    chk("f1_qspi",   ena_qspi,    1'b1);
    chk("f1_count",  fifo_count,  1);

    // Read frame with truncated length, visible after popping the first
    send_frame(8'hA0, 16'hFFFF, 24'h000001, 1'b0);
    idle(1, 1'b1);
    chk("f2_rw",   cmd_r_w,     1'b1);
    chk("f2_len",  cmd_length,  9'h1FF);
    chk("f2_addr", cmd_address, 24'h000001);

    // Dropped frame
    send_frame(8'h60, 16'h1234, 24'hABCDEF, 1'b0);
    chk("drop_count", fifo_count, 1);
    chk("drop_err",   err_count,  1);
    idle(2, 1'b1);

    // Fill to DEPTH, stall on the fifth frame's last byte, wrap order
    do_reset();
    for (int i = 0; i < 4; i++)
      send_frame(8'(i % 3) << 5, 16'(i), 24'(i + 1), 1'b0);
    send_byte(8'h00, 1'b0);
    send_byte(8'h00, 1'b0);
    send_byte(8'h04, 1'b0);
    send_byte(8'h00, 1'b0);
    send_byte(8'h00, 1'b0);
    chk("full_count", fifo_count, 4);
    chk("full_ready", in_ready,   1'b0);
    cycle(1'b1, 8'h05, 1'b1, 1'b0, 1'b0, acc_o);
    chk("pop_no_push_count", fifo_count, 3);
    chk("pop_no_push_ready", in_ready,   1'b1);
    cycle(1'b1, 8'h05, 1'b0, 1'b0, 1'b0, acc_o);
    chk("refill_count", fifo_count, 4);
    for (int k = 2; k <= 5; k++) begin
      chk("wrap_order", cmd_address, 24'(k));
      idle(1, 1'b1);
    end
    chk("drained", cmd_valid, 1'b0);

    // Pending acks
    for (int i = 0; i < 3; i++) cycle(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, acc_o);
    g = 0;
    for (int i = 0; i < 8; i++) begin
      if (ack_req) g++;
      cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, acc_o);
    end
    chk("ack_grants", g, 3);
    cycle(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, acc_o);
    cycle(1'b0, 8'h00, 1'b0, 1'b1, 1'b1, acc_o);
    chk("ack_coincident", ack_req, 1'b1);
    cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, acc_o);
    chk("ack_retired", ack_req, 1'b0);
    for (int i = 0; i < 6; i++) cycle(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, acc_o);
    g = 0;
    for (int i = 0; i < 8; i++) begin
      if (ack_req) g++;
      cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, acc_o);
    end
    chk("ack_saturate", g, DEPTH);

    // Reset in the middle of a frame
    send_byte(8'h20, 1'b0);
    send_byte(8'h00, 1'b0);
    send_byte(8'h10, 1'b0);
    do_reset();
    chk("mid_rst_ready", in_ready,   1'b1);
    chk("mid_rst_tgt",   cmd_target, 2'b00);
    send_frame(8'h40, 16'h0005, 24'hABCDEF, 1'b0);
    chk("mid_rst_count",  fifo_count,  1);
    chk("mid_rst_addr",   cmd_address, 24'hABCDEF);
    chk("mid_rst_status", ena_status,  1'b1);

    // Randomized traffic against the model
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      rst_n = ($urandom_range(0, 499) != 0);
      cycle($urandom_range(0, 3) != 0, 8'($urandom), $urandom_range(0, 3) == 0,
            $urandom_range(0, 4) == 0, $urandom_range(0, 2) == 0, acc_o);
    end
    rst_n = 1'b1;

    // err_count saturation
    do_reset();
    for (int i = 0; i < 257; i++) send_frame(8'hE0, 16'h0000, 24'h000000, 1'b0);
    chk("err_saturate", err_count, 255);
    chk("err_no_queue", fifo_count, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
